// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared sizing defaults and pointer/count width helpers for sync_fifo8
package fifo_pkg;

    localparam int FIFO_WIDTH = 8;
    localparam int FIFO_DEPTH = 8;

    localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

    function automatic int ptr_bits(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int cnt_bits(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - DEPTH x WIDTH storage, synchronous write, asynchronous read
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int DEPTH = FIFO_DEPTH,
    parameter int AW    = ptr_bits(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    // Contents are intentionally not reset; the controller's count gates validity.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo8.sv
// rtl/sync_fifo8.sv - first-word fall-through synchronous FIFO with sticky overflow flag
module sync_fifo8
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow
);

    localparam int PW = ptr_bits(DEPTH);
    localparam int CW = cnt_bits(DEPTH);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          full;

    // Handshake flags come only from registered occupancy, never from in_valid.
    assign full      = (count == CW'(DEPTH));
    assign in_ready  = !full;
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (in_data),
        .raddr (rd_ptr),
        .rdata (out_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            // Power-of-two depth lets the pointers wrap by plain overflow.
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (in_valid && full) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo8.sv
// tb/tb_sync_fifo8.sv - directed self-checking bench for sync_fifo8
module tb_sync_fifo8;

    logic       clk;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] count;
    logic       overflow;

    int n_cmp;
    int n_bad;

    sync_fifo8 dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change at the falling edge, one rising edge applies them, outputs read at the next falling edge.
    task automatic step(input logic iv, input logic [7:0] d, input logic ordy);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic fill_1_to_8();
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 8'(i), 1'b0);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_count", 32'(count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;

        // Three pushes with downstream stalled, then drain in order.
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        step(1'b1, 8'h33, 1'b0);
        check("p3_count", 32'(count), 32'd3);
        check("p3_out_valid", 32'(out_valid), 32'd1);
        check("p3_out_data", 32'(out_data), 32'h11);
        check("p3_head2", 32'(out_data), 32'h11);
        step(1'b0, 8'h00, 1'b1);
        check("p3_head2", 32'(out_data), 32'h22);
        step(1'b0, 8'h00, 1'b1);
        check("p3_head3", 32'(out_data), 32'h33);
        step(1'b0, 8'h00, 1'b1);
        check("p3_empty", 32'(out_valid), 32'd0);

        // Overflow: extra write while full is dropped and flagged.
        do_reset();
        fill_1_to_8();
        check("full_count", 32'(count), 32'd8);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_ovf_clear", 32'(overflow), 32'd0);
        step(1'b1, 8'hFF, 1'b0);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd8);
        check("ovf_in_ready", 32'(in_ready), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("ovf_drain_valid%0d", i), 32'(out_valid), 32'd1);
            check($sformatf("ovf_drain_data%0d", i), 32'(out_data), 32'(i));
            step(1'b0, 8'h00, 1'b1);
        end
        check("ovf_drained", 32'(out_valid), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Full with push offered and pop taken in the same cycle.
        do_reset();
        fill_1_to_8();
        step(1'b1, 8'hEE, 1'b1);
        check("fpp_count", 32'(count), 32'd7);
        check("fpp_in_ready", 32'(in_ready), 32'd1);
        check("fpp_head", 32'(out_data), 32'h02);
        check("fpp_overflow", 32'(overflow), 32'd1);

        // Streaming 20 bytes through, wrapping pointers twice.
        do_reset();
        step(1'b1, 8'h00, 1'b0);
        for (int i = 1; i < 20; i++) begin
            check($sformatf("stream_data%0d", i - 1), 32'(out_data), 32'(i - 1));
            step(1'b1, 8'(i), 1'b1);
            check($sformatf("stream_count%0d", i), 32'(count), 32'd1);
        end
        check("stream_last", 32'(out_data), 32'h13);
        step(1'b0, 8'h00, 1'b1);
        check("stream_empty_count", 32'(count), 32'd0);

        // Empty with pop requested and push offered together.
        do_reset();
        step(1'b1, 8'hA5, 1'b1);
        check("epp_count", 32'(count), 32'd1);
        check("epp_out_valid", 32'(out_valid), 32'd1);
        check("epp_out_data", 32'(out_data), 32'hA5);

        // Asynchronous reset between edges discards contents.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'(8'h40 + i), 1'b0);
        end
        check("ar_pre_count", 32'(count), 32'd5);
        #2;
        reset = 1'b1;
        #1;
        check("ar_count", 32'(count), 32'd0);
        check("ar_out_valid", 32'(out_valid), 32'd0);
        check("ar_overflow", 32'(overflow), 32'd0);
        check("ar_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 8'h5A, 1'b0);
        check("ar_post_count", 32'(count), 32'd1);
        check("ar_post_head", 32'(out_data), 32'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
